// File: rtl/sub3_seq.sv
// Sequential unsigned subtractor: D = A - B, three bits per clock through a
// borrow-lookahead slice. Define SUB3_SEQ_SAT_EN for a saturating (clamp-to-zero) result.
module sub3_seq #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             borrow_out,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / 3;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [2:0]       a_sl_c, b_sl_c, nb_c, g_c, p_c, s_c;
    logic [3:0]       c_c;
    logic             last_c;
    logic [WIDTH-1:0] d_ins_c;

    // Select the active 3-bit slice of each operand
    always_comb begin
        a_sl_c = '0;
        b_sl_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                a_sl_c = a_q[3*i +: 3];
                b_sl_c = b_q[3*i +: 3];
            end
        end
        last_c = (k_q == KW'(N - 1));
    end

    // Lookahead slice: A + ~B + carry, carry-out computed from g/p, not rippled
    always_comb begin
        nb_c   = ~b_sl_c;
        g_c    = a_sl_c & nb_c;
        p_c    = a_sl_c ^ nb_c;
        c_c[0] = carry_q;
        c_c[1] = g_c[0] | (p_c[0] & carry_q);
        c_c[2] = g_c[1] | (p_c[1] & g_c[0]) | (p_c[1] & p_c[0] & carry_q);
        c_c[3] = g_c[2] | (p_c[2] & g_c[1]) | (p_c[2] & p_c[1] & g_c[0])
               | (p_c[2] & p_c[1] & p_c[0] & carry_q);
        s_c    = p_c ^ c_c[2:0];
    end

    // Current result with the active slice overwritten by the slice sum
    always_comb begin
        d_ins_c = d_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                d_ins_c[3*i +: 3] = s_c;
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        d_d         = d_q;
        borrow_d    = borrow_q;
        zero_d      = zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d        = A;
                    b_d        = B;
                    k_d        = '0;
                    carry_d    = 1'b1;
                    d_d        = '0;
                    borrow_d   = 1'b0;
                    zero_d     = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                d_d     = d_ins_c;
                carry_d = c_c[3];
                k_d     = k_q + KW'(1);
                if (last_c) begin
                    k_d         = '0;
                    borrow_d    = ~c_c[3];
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
`ifdef SUB3_SEQ_SAT_EN
                    // Underflow clamps to zero; borrow still reports it
                    d_d    = c_c[3] ? d_ins_c : '0;
                    zero_d = ~c_c[3] | (d_ins_c == '0);
`else
                    zero_d = (d_ins_c == '0);
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State register, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            d_q         <= '0;
            borrow_q    <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            d_q         <= d_d;
            borrow_q    <= borrow_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign D          = d_q;
    assign borrow_out = borrow_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_sub3_seq.sv
// Directed-vector bench for sub3_seq at WIDTH = 9; honours SUB3_SEQ_SAT_EN.
module tb_sub3_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] A;
    logic [8:0] B;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] D;
    logic       borrow_out;
    logic       zero;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sub3_seq #(.WIDTH(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .D          (D),
        .borrow_out (borrow_out),
        .zero       (zero)
    );

    // Drive one operand pair, scramble inputs after accept, wait (bounded) for out_valid
    task automatic run_op(input logic [8:0] a, input logic [8:0] b, output int lat);
        @(negedge clk);
        A = a;
        B = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        A = ~a;
        B = ~b;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        vectors++;
        if (D !== 9'd0) begin miscompares++; $display("FAIL reset_D got %0d want 0", D); end
        vectors++;
        if (borrow_out !== 1'b0) begin miscompares++; $display("FAIL reset_borrow got %0b want 0", borrow_out); end
        vectors++;
        if (zero !== 1'b0) begin miscompares++; $display("FAIL reset_zero got %0b want 0", zero); end
    endtask

    task automatic test_basic();
        int lat;
        run_op(9'd300, 9'd45, lat);
        vectors++;
        if (lat !== 3) begin miscompares++; $display("FAIL basic_latency got %0d want 3", lat); end
        vectors++;
        if (D !== 9'd255) begin miscompares++; $display("FAIL basic_D got %0d want 255", D); end
        vectors++;
        if (borrow_out !== 1'b0) begin miscompares++; $display("FAIL basic_borrow got %0b want 0", borrow_out); end
        vectors++;
        if (zero !== 1'b0) begin miscompares++; $display("FAIL basic_zero got %0b want 0", zero); end
        release_result();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_return_idle got in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_underflow();
        int lat;
        run_op(9'd5, 9'd9, lat);
        vectors++;
        if (lat !== 3) begin miscompares++; $display("FAIL under_latency got %0d want 3", lat); end
`ifdef SUB3_SEQ_SAT_EN
        vectors++;
        if (D !== 9'd0) begin miscompares++; $display("FAIL under_D got %0d want 0", D); end
        vectors++;
        if (zero !== 1'b1) begin miscompares++; $display("FAIL under_zero got %0b want 1", zero); end
`else
        vectors++;
        if (D !== 9'd508) begin miscompares++; $display("FAIL under_D got %0d want 508", D); end
        vectors++;
        if (zero !== 1'b0) begin miscompares++; $display("FAIL under_zero got %0b want 0", zero); end
`endif
        vectors++;
        if (borrow_out !== 1'b1) begin miscompares++; $display("FAIL under_borrow got %0b want 1", borrow_out); end
        release_result();
    endtask

    task automatic test_cross_slice();
        int lat;
        run_op(9'd511, 9'd511, lat);
        vectors++;
        if (D !== 9'd0) begin miscompares++; $display("FAIL equal_D got %0d want 0", D); end
        vectors++;
        if (borrow_out !== 1'b0) begin miscompares++; $display("FAIL equal_borrow got %0b want 0", borrow_out); end
        vectors++;
        if (zero !== 1'b1) begin miscompares++; $display("FAIL equal_zero got %0b want 1", zero); end
        release_result();
        run_op(9'd64, 9'd1, lat);
        vectors++;
        if (D !== 9'd63) begin miscompares++; $display("FAIL chain_D got %0d want 63", D); end
        vectors++;
        if (borrow_out !== 1'b0 || zero !== 1'b0) begin
            miscompares++;
            $display("FAIL chain_flags got borrow=%0b zero=%0b want 0/0", borrow_out, zero);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(9'd100, 9'd30, lat);
        vectors++;
        if (D !== 9'd70) begin miscompares++; $display("FAIL bp_D_initial got %0d want 70", D); end
        for (int i = 0; i < 5; i++) begin
            A = 9'($urandom_range(0, 511));
            B = 9'($urandom_range(0, 511));
            in_valid = ~in_valid;
            @(negedge clk);
            vectors++;
            if (D !== 9'd70 || borrow_out !== 1'b0 || zero !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d got D=%0d borrow=%0b zero=%0b in_ready=%0b out_valid=%0b want 70/0/0/0/1",
                         i, D, borrow_out, zero, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        release_result();
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        @(negedge clk);
        A = 9'd200;
        B = 9'd50;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || D !== 9'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_state got out_valid=%0b D=%0d in_ready=%0b want 0/0/1", out_valid, D, in_ready);
        end
        rst = 1'b0;
        run_op(9'd10, 9'd3, lat);
        vectors++;
        if (lat !== 3) begin miscompares++; $display("FAIL midrst_latency got %0d want 3", lat); end
        vectors++;
        if (D !== 9'd7) begin miscompares++; $display("FAIL midrst_D got %0d want 7", D); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_cross_slice();
        test_backpressure();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
